// File: rtl/psk_pkg.sv
// Shared types and constants for the PSK frame scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package psk_pkg;

  // Frame sequencing states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_HDR  = 3'd2,
    ST_PAY  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Header is one mode bit followed by the 8-bit payload length
  localparam int HDR_LEN = 9;

  // Payload symbols needed to carry one byte
  localparam int SPB_BPSK = 8;
  localparam int SPB_QPSK = 4;

  // Default preamble bit pattern
  localparam logic [31:0] PRE_PAT_DEF = 32'hA5F0_A5F0;

endpackage

// File: rtl/sym_tick_gen.sv
// Symbol-rate tick generator: one-cycle tick every SYM_DIV enabled cycles.
// Latency: tick is combinational on the clear cycle, then every SYM_DIV cycles.
// Backpressure: none; counts freely while enabled.
module sym_tick_gen #(
  parameter int SYM_DIV = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (SYM_DIV > 2) ? $clog2(SYM_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SYM_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Clear restarts the period and ticks immediately; otherwise wrap at LAST
  always_comb begin
    tick  = clr | (en & (cnt_q == LAST));
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  // Divider counter register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/psk_frame_scheduler.sv
// Sequences one PSK burst: BPSK preamble, BPSK header, BPSK/QPSK payload bytes.
// Latency: first symbol one cycle after start accept; one symbol per SYM_DIV cycles.
// Backpressure: byte_rdy gated by a one-entry hold register; an empty hold at a byte boundary gives an idle underrun symbol.
module psk_frame_scheduler
  import psk_pkg::*;
#(
  parameter int          SYM_DIV = 8,
  parameter int          PRE_LEN = 16,
  parameter logic [31:0] PRE_PAT = PRE_PAT_DEF,
  parameter int          M       = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         qpsk_en,
  input  logic [7:0]   len,
  input  logic [7:0]   byte_data,
  input  logic         byte_vld,
  output logic         byte_rdy,
  output logic [M-1:0] sym,
  output logic         sym_vld,
  output logic         bypass,
  output logic         busy,
  output logic         done,
  output logic         underrun
);

  localparam logic [5:0] PRE_LEN_C = 6'(PRE_LEN);
  localparam logic [5:0] HDR_LEN_C = 6'(HDR_LEN);

  state_t         state_q, state_d;
  logic [M-1:0]   sym_q, sym_d;
  logic           sym_vld_q, sym_vld_d;
  logic           bypass_q, bypass_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           underrun_q, underrun_d;
  logic           qpsk_q, qpsk_d;
  logic [7:0]     len_q, len_d;
  logic [7:0]     hold_q, hold_d;
  logic           hold_full_q, hold_full_d;
  logic [7:0]     shift_q, shift_d;
  logic [7:0]     fetched_q, fetched_d;
  logic [7:0]     byte_cnt_q, byte_cnt_d;
  logic [5:0]     sym_cnt_q, sym_cnt_d;

  logic       tick;
  logic       start_acc;
  logic       xfer;
  logic [5:0] spb;
  logic [4:0] pre_idx;
  logic       pre_bit;
  logic [8:0] hdr_word;
  logic [3:0] hdr_idx;
  logic       hdr_bit;

  // Start is only honoured in IDLE; ignored while a frame is in flight
  assign start_acc = (state_q == ST_IDLE) & start;
  assign byte_rdy  = busy_q & ~hold_full_q & (fetched_q < len_q);
  assign xfer      = byte_vld & byte_rdy;
  assign spb       = qpsk_q ? 6'(SPB_QPSK) : 6'(SPB_BPSK);

  // Preamble sent MSB first of the low PRE_LEN bits; the accept tick sends bit PRE_LEN-1
  assign pre_idx  = 5'(PRE_LEN - 1) - ((state_q == ST_PRE) ? sym_cnt_q[4:0] : 5'd0);
  assign pre_bit  = PRE_PAT[pre_idx];
  // Header word: mode bit then length MSB first; the PRE->HDR tick sends bit 8
  assign hdr_word = {qpsk_q, len_q};
  assign hdr_idx  = 4'd8 - ((state_q == ST_HDR) ? sym_cnt_q[3:0] : 4'd0);
  assign hdr_bit  = hdr_word[hdr_idx];

  sym_tick_gen #(
    .SYM_DIV (SYM_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_acc),
    .en   (busy_q),
    .tick (tick)
  );

  // Next-state: byte intake, per-tick symbol selection and frame sequencing
  always_comb begin
    logic       do_bpsk, bpsk_bit, do_pay, do_bound, do_end;
    logic [7:0] pay_v;

    state_d     = state_q;
    sym_d       = sym_q;
    sym_vld_d   = sym_vld_q;
    bypass_d    = bypass_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    underrun_d  = 1'b0;
    qpsk_d      = qpsk_q;
    len_d       = len_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    fetched_d   = fetched_q;
    byte_cnt_d  = byte_cnt_q;
    sym_cnt_d   = sym_cnt_q;
    do_bpsk     = 1'b0;
    bpsk_bit    = 1'b0;
    do_pay      = 1'b0;
    do_bound    = 1'b0;
    do_end      = 1'b0;
    pay_v       = shift_q;

    if (xfer) begin
      hold_d      = byte_data;
      hold_full_d = 1'b1;
      fetched_d   = fetched_q + 8'd1;
    end

    if (state_q == ST_DONE) state_d = ST_IDLE;

    if (tick) begin
      unique case (state_q)
        ST_IDLE: begin
          state_d     = ST_PRE;
          busy_d      = 1'b1;
          qpsk_d      = qpsk_en;
          len_d       = len;
          fetched_d   = 8'd0;
          byte_cnt_d  = 8'd0;
          hold_full_d = 1'b0;
          sym_cnt_d   = 6'd1;
          do_bpsk     = 1'b1;
          bpsk_bit    = pre_bit;
        end
        ST_PRE: begin
          do_bpsk = 1'b1;
          if (sym_cnt_q == PRE_LEN_C) begin
            state_d   = ST_HDR;
            sym_cnt_d = 6'd1;
            bpsk_bit  = hdr_bit;
          end else begin
            sym_cnt_d = sym_cnt_q + 6'd1;
            bpsk_bit  = pre_bit;
          end
        end
        ST_HDR: begin
          if (sym_cnt_q == HDR_LEN_C) begin
            if (len_q == 8'd0) begin
              do_end = 1'b1;
            end else begin
              state_d  = ST_PAY;
              do_bound = 1'b1;
            end
          end else begin
            do_bpsk   = 1'b1;
            bpsk_bit  = hdr_bit;
            sym_cnt_d = sym_cnt_q + 6'd1;
          end
        end
        ST_PAY: begin
          if ((sym_cnt_q == spb) && (byte_cnt_q == len_q)) begin
            do_end = 1'b1;
          end else if ((sym_cnt_q == spb) || (sym_cnt_q == 6'd0)) begin
            do_bound = 1'b1;
          end else begin
            do_pay    = 1'b1;
            sym_cnt_d = sym_cnt_q + 6'd1;
          end
        end
        default: ;
      endcase
    end

    // Byte boundary: move hold into the shifter, or idle the period and retry next tick
    if (do_bound) begin
      if (hold_full_q) begin
        do_pay      = 1'b1;
        pay_v       = hold_q;
        hold_full_d = 1'b0;
        byte_cnt_d  = byte_cnt_q + 8'd1;
        sym_cnt_d   = 6'd1;
      end else begin
        underrun_d = 1'b1;
        sym_vld_d  = 1'b0;
        sym_d      = '0;
        bypass_d   = ~qpsk_q;
        sym_cnt_d  = 6'd0;
      end
    end

    if (do_pay) begin
      sym_vld_d = 1'b1;
      sym_d     = '0;
      if (qpsk_q) begin
        sym_d[1:0] = pay_v[7:6];
        shift_d    = {pay_v[5:0], 2'b00};
        bypass_d   = 1'b0;
      end else begin
        sym_d[1:0] = {2{pay_v[7]}};
        shift_d    = {pay_v[6:0], 1'b0};
        bypass_d   = 1'b1;
      end
    end

    if (do_bpsk) begin
      sym_vld_d  = 1'b1;
      sym_d      = '0;
      sym_d[1:0] = {2{bpsk_bit}};
      bypass_d   = 1'b1;
    end

    if (do_end) begin
      state_d   = ST_DONE;
      sym_vld_d = 1'b0;
      sym_d     = '0;
      bypass_d  = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b1;
    end
  end

  // State and registered outputs; reset drops any partial frame
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sym_q       <= '0;
      sym_vld_q   <= 1'b0;
      bypass_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
      qpsk_q      <= 1'b0;
      len_q       <= 8'd0;
      hold_q      <= 8'd0;
      hold_full_q <= 1'b0;
      shift_q     <= 8'd0;
      fetched_q   <= 8'd0;
      byte_cnt_q  <= 8'd0;
      sym_cnt_q   <= 6'd0;
    end else begin
      state_q     <= state_d;
      sym_q       <= sym_d;
      sym_vld_q   <= sym_vld_d;
      bypass_q    <= bypass_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      underrun_q  <= underrun_d;
      qpsk_q      <= qpsk_d;
      len_q       <= len_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      fetched_q   <= fetched_d;
      byte_cnt_q  <= byte_cnt_d;
      sym_cnt_q   <= sym_cnt_d;
    end
  end

  assign sym      = sym_q;
  assign sym_vld  = sym_vld_q;
  assign bypass   = bypass_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_psk_frame_scheduler.sv
// Directed bench for psk_frame_scheduler: whole frames checked symbol by symbol.
// Latency: symbol k sampled at the falling edge t+1+8k after the start edge t.
// Backpressure: a byte feeder process serves a queue; bytes can be held back to force underruns.
module tb_psk_frame_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       qpsk_en;
  logic [7:0] len;
  logic [7:0] byte_data;
  logic       byte_vld;
  logic       byte_rdy;
  logic [7:0] sym;
  logic       sym_vld;
  logic       bypass;
  logic       busy;
  logic       done;
  logic       underrun;

  int errors = 0;
  int checks = 0;

  logic [7:0] byte_q[$];
  bit         pend = 1'b0;

  int exp_vld[$];
  int exp_sym[$];
  int exp_byp[$];
  int exp_ur[$];
  int ur_cnt = 0;

  psk_frame_scheduler #(
    .SYM_DIV (8),
    .PRE_LEN (16),
    .PRE_PAT (32'hA5F0_A5F0),
    .M       (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .qpsk_en   (qpsk_en),
    .len       (len),
    .byte_data (byte_data),
    .byte_vld  (byte_vld),
    .byte_rdy  (byte_rdy),
    .sym       (sym),
    .sym_vld   (sym_vld),
    .bypass    (bypass),
    .busy      (busy),
    .done      (done),
    .underrun  (underrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (underrun) ur_cnt++;

  // Byte source: offers the queue head; pops once the rising edge has taken it
  initial begin
    byte_vld  = 1'b0;
    byte_data = 8'd0;
    forever begin
      @(negedge clk);
      #2;
      if (pend && byte_q.size() > 0) void'(byte_q.pop_front());
      if (byte_q.size() > 0) begin
        byte_vld  = 1'b1;
        byte_data = byte_q[0];
      end else begin
        byte_vld  = 1'b0;
        byte_data = 8'd0;
      end
      pend = byte_vld && byte_rdy;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int v, input int s, input int b, input int u);
    exp_vld.push_back(v);
    exp_sym.push_back(s);
    exp_byp.push_back(b);
    exp_ur.push_back(u);
  endtask

  task automatic clear_exp();
    exp_vld.delete();
    exp_sym.delete();
    exp_byp.delete();
    exp_ur.delete();
  endtask

  // Preamble 0xA5F0 MSB first, then header {mode, len MSB first}
  task automatic build_pre_hdr(input logic q, input logic [7:0] l);
    logic [15:0] pre;
    logic [8:0]  hdr;
    pre = 16'hA5F0;
    hdr = {q, l};
    for (int i = 15; i >= 0; i--) push(1, pre[i] ? 3 : 0, 1, 0);
    for (int i = 8; i >= 0; i--)  push(1, hdr[i] ? 3 : 0, 1, 0);
  endtask

  // Starts a frame at this falling edge and checks every symbol period plus the frame end
  task automatic run_frame(input logic q, input logic [7:0] l, input logic no_rdy,
                           input int poke_k, input int push_k, input logic [7:0] push_v);
    int f;
    f       = exp_vld.size();
    ur_cnt  = 0;
    start   = 1'b1;
    qpsk_en = q;
    len     = l;
    @(negedge clk);
    start   = 1'b0;
    qpsk_en = 1'b0;
    len     = 8'd0;
    for (int k = 0; k < f; k++) begin
      chk($sformatf("sym_vld[%0d]", k), 32'(sym_vld), 32'(exp_vld[k]));
      chk($sformatf("sym[%0d]", k), 32'(sym), 32'(exp_sym[k]));
      chk($sformatf("bypass[%0d]", k), 32'(bypass), 32'(exp_byp[k]));
      chk($sformatf("underrun[%0d]", k), 32'(underrun), 32'(exp_ur[k]));
      chk($sformatf("busy[%0d]", k), 32'(busy), 32'd1);
      if (no_rdy) chk($sformatf("byte_rdy[%0d]", k), 32'(byte_rdy), 32'd0);
      if (k == push_k) byte_q.push_back(push_v);
      if (k == poke_k) begin
        start   = 1'b1;
        qpsk_en = ~q;
        len     = 8'd7;
        @(negedge clk);
        start   = 1'b0;
        qpsk_en = 1'b0;
        len     = 8'd0;
        repeat (7) @(negedge clk);
      end else if (k < f - 1) begin
        repeat (8) @(negedge clk);
      end
    end
    repeat (7) @(negedge clk);
    chk("pre_end_done", 32'(done), 32'd0);
    chk("pre_end_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("end_done", 32'(done), 32'd1);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_sym_vld", 32'(sym_vld), 32'd0);
    chk("end_sym", 32'(sym), 32'd0);
    @(negedge clk);
    chk("post_done", 32'(done), 32'd0);
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    qpsk_en = 1'b0;
    len     = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_sym", 32'(sym), 32'd0);
    chk("rst_sym_vld", 32'(sym_vld), 32'd0);
    chk("rst_bypass", 32'(bypass), 32'd0);
    chk("rst_byte_rdy", 32'(byte_rdy), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Header-only BPSK frame: 25 symbols, no byte requests
    clear_exp();
    build_pre_hdr(1'b0, 8'd0);
    run_frame(1'b0, 8'd0, 1'b1, -1, -1, 8'd0);

    // Back-to-back QPSK frame, len 2, bytes queued up front
    clear_exp();
    build_pre_hdr(1'b1, 8'd2);
    push(1, 2, 0, 0); push(1, 3, 0, 0); push(1, 1, 0, 0); push(1, 0, 0, 0);
    push(1, 0, 0, 0); push(1, 1, 0, 0); push(1, 3, 0, 0); push(1, 2, 0, 0);
    chk("qpsk_F", 32'(exp_vld.size()), 32'd33);
    byte_q.push_back(8'hB4);
    byte_q.push_back(8'h1E);
    run_frame(1'b1, 8'd2, 1'b0, -1, -1, 8'd0);

    // BPSK len 1, byte 0x81, with a start pulse mid-frame that must be ignored
    clear_exp();
    build_pre_hdr(1'b0, 8'd1);
    push(1, 3, 1, 0);
    for (int i = 0; i < 6; i++) push(1, 0, 1, 0);
    push(1, 3, 1, 0);
    chk("bpsk_hdr0", 32'(exp_sym[16]), 32'd0);
    byte_q.push_back(8'h81);
    run_frame(1'b0, 8'd1, 1'b0, 20, -1, 8'd0);

    // QPSK len 2 with the second byte held back for three symbol periods
    clear_exp();
    build_pre_hdr(1'b1, 8'd2);
    push(1, 2, 0, 0); push(1, 3, 0, 0); push(1, 1, 0, 0); push(1, 0, 0, 0);
    push(0, 0, 0, 1); push(0, 0, 0, 1); push(0, 0, 0, 1);
    push(1, 0, 0, 0); push(1, 1, 0, 0); push(1, 3, 0, 0); push(1, 2, 0, 0);
    byte_q.push_back(8'hB4);
    run_frame(1'b1, 8'd2, 1'b0, -1, 31, 8'h1E);
    chk("underrun_total", 32'(ur_cnt), 32'd3);

    // Reset in the middle of a payload
    byte_q.push_back(8'hB4);
    byte_q.push_back(8'h1E);
    start   = 1'b1;
    qpsk_en = 1'b1;
    len     = 8'd2;
    @(negedge clk);
    start   = 1'b0;
    qpsk_en = 1'b0;
    len     = 8'd0;
    repeat (8 * 27) @(negedge clk);
    chk("mid_pay_busy", 32'(busy), 32'd1);
    chk("mid_pay_bypass", 32'(bypass), 32'd0);
    rst = 1'b1;
    byte_q.delete();
    @(negedge clk);
    chk("mrst_sym", 32'(sym), 32'd0);
    chk("mrst_sym_vld", 32'(sym_vld), 32'd0);
    chk("mrst_bypass", 32'(bypass), 32'd0);
    chk("mrst_byte_rdy", 32'(byte_rdy), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_underrun", 32'(underrun), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Fresh frame after reset: preamble starts one cycle after start
    clear_exp();
    build_pre_hdr(1'b0, 8'd0);
    run_frame(1'b0, 8'd0, 1'b1, -1, -1, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
